traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Demand-actuated phase scheduler for the 4-way intersection. Latches per-approach vehicle requests.
//  Grants green to one approach at a time in round-robin order (N->S->E->W), skipping approaches with no demand.
//  Enforces min/max green, yellow and all-red clearance, all timed on an external tick strobe.
//  Drives the n/s/e/w light outputs directly. Replaces the fixed-cycle sequencer.
// PARAMETERS
//  CNT_W     4   phase timer width; every timing parameter must be <= 2**CNT_W-1
//  GREEN_MIN 4   ticks of green before a competing request can end the phase (>=1)
//  GREEN_MAX 12  ticks of green after which the phase is forced to end if another request pends (>=GREEN_MIN)
//  YELLOW_T  3   ticks of yellow (>=1)
//  ALLRED_T  1   ticks of all-red clearance after yellow (>=1)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  tick_en      in   1  one-clk timebase strobe; timers advance only when it is high
//  req          in   4  vehicle-present level per approach, bit0=N, 1=S, 2=E, 3=W
//  n_lights     out  2  2'b10 green, 2'b01 yellow, 2'b00 red (same for s/e/w)
//  s_lights     out  2
//  e_lights     out  2
//  w_lights     out  2
//  grant        out  4  one-hot approach currently green or yellow; 0 in IDLE and ALLRED
//  pending      out  4  latched, not-yet-served requests
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, all lights 2'b00, grant=0, pending=0, timer=0, last=W (so N wins first).
//  - All outputs registered; at most one approach is non-red at any time.
//  - pending[i] is set on any edge with req[i]=1, except while i holds grant. It is cleared on the edge that grants i. Grant wins over a simultaneous set.
//  - FSM states and transitions:
//    - IDLE: all red. When pending!=0, go to GREEN next edge for the RR winner (first pending after `last`). No tick is needed.
//    - GREEN: timer counts ticks from 0. Let o = pending & ~grant.
//      - Go to YELLOW when o!=0 and timer>=GREEN_MIN.
//      - Go to YELLOW when o!=0 and timer reaches GREEN_MAX.
//      - If o==0, rest in green indefinitely; the timer saturates at 2**CNT_W-1.
//    - YELLOW: lasts exactly YELLOW_T ticks. Leave on the edge where tick_en=1 and timer==YELLOW_T-1.
//    - ALLRED: all red, grant=0, lasts ALLRED_T ticks. Then GREEN for the RR winner after `last`, or IDLE if pending==0.
//  - A phase of N ticks means the timer resets to 0 on state entry and exits at count N-1 with tick_en=1.
//  - `last` updates to the granted approach on entry to GREEN.
//  - Latency: req high before edge k sets pending at edge k; green appears after edge k+1 (from IDLE).
//  - A request that drops before being latched is lost; once latched it is served even if req drops.
//  - Reset mid-phase: lights go to all red immediately (async), with no yellow.
// CONFIGURATION
//  Macro EMERGENCY_PREEMPT_EN adds ports preempt (in, 1) and preempt_dir (in, 2; 0=N, 1=S, 2=E, 3=W).
//  - With the macro, while preempt=1:
//    - GREEN on preempt_dir holds, ignoring GREEN_MAX.
//    - GREEN on another approach goes to YELLOW next edge, ignoring GREEN_MIN.
//    - YELLOW and ALLRED run to completion, then grant preempt_dir regardless of RR or pending.
//    - IDLE grants preempt_dir next edge.
//    - `last` updates normally. When preempt drops, normal RR resumes.
//  - Without the macro, the ports are absent and behaviour is exactly as above.
// STRUCTURE
//  - Package traffic_pkg holds:
//    - dir_t enum {DIR_N=0, DIR_S, DIR_E, DIR_W}
//    - light_t enum {RED=2'b00, YELLOW=2'b01, GREEN=2'b10}
//    - phase_t enum {IDLE, GREEN_PH, YELLOW_PH, ALLRED_PH}
//  - Sub-module rr_arbiter4: combinational. Takes req[3:0] and last (dir_t). Produces a one-hot gnt and a valid flag.
//  - Parameter legality is checked with elaboration-time assertions.
// TESTING
//  1. Reset then req=4'b0001 for one clk -> N green two edges later; it rests green with no other demand; pending=0.
//  2. N green, req[E] pulsed at tick 1 -> N stays green until tick 4, then 3 ticks yellow, 1 tick all-red, then E green.
//  3. req=4'b1111 held from reset -> order N,S,E,W,N...; each green lasts exactly GREEN_MIN=4 ticks.
//  4. S green with GREEN_MIN raised to 12, req[W] set -> S forced to yellow at tick 12; W served next.
//  5. req[N] asserted while N is green -> not latched; after N's phase ends with S pending, N is not re-served.
//  6. EMERGENCY_PREEMPT_EN, E green at tick 1, preempt=1 with dir=W -> E yellow next edge, then all-red, then W green held while preempt=1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the demand-actuated intersection phase scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        IDLE,
        GREEN_PH,
        YELLOW_PH,
        ALLRED_PH
    } phase_t;

    function automatic logic [3:0] dir_onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

    function automatic dir_t onehot_to_dir(input logic [3:0] oh);
        dir_t d;
        d = DIR_N;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) d = dir_t'(2'(k));
        end
        return d;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_rr_arbiter4.sv
// Combinational round-robin picker: first requesting approach strictly after `last`, wrapping to `last` itself.
module rr_arbiter4
    import traffic_pkg::*;
(
    input  logic [3:0] req,
    input  dir_t       last,
    output logic [3:0] gnt,
    output logic       valid
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt   = 4'b0000;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = 2'(int'(last) + k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated 4-way phase scheduler with min/max green, yellow and all-red timed on tick_en.
// Optional emergency pre-emption is compiled in with the EMERGENCY_PREEMPT_EN macro.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic [3:0] req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       preempt,
    input  logic [1:0] preempt_dir,
`endif
    output logic [1:0] n_lights,
    output logic [1:0] s_lights,
    output logic [1:0] e_lights,
    output logic [1:0] w_lights,
    output logic [3:0] grant,
    output logic [3:0] pending
);

    localparam int TMAX_INT = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] TIMER_MAX  = '1;
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W:0]   MIN_TICKS  = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   MAX_TICKS  = (CNT_W+1)'(GREEN_MAX);

    if (GREEN_MIN < 1 || GREEN_MIN > TMAX_INT) begin : g_chk_min
        $error("GREEN_MIN out of range");
    end
    if (GREEN_MAX < GREEN_MIN || GREEN_MAX > TMAX_INT) begin : g_chk_max
        $error("GREEN_MAX out of range");
    end
    if (YELLOW_T < 1 || YELLOW_T > TMAX_INT) begin : g_chk_yel
        $error("YELLOW_T out of range");
    end
    if (ALLRED_T < 1 || ALLRED_T > TMAX_INT) begin : g_chk_ar
        $error("ALLRED_T out of range");
    end

    logic pre_act;
    dir_t pre_dir;
`ifdef EMERGENCY_PREEMPT_EN
    assign pre_act = preempt;
    assign pre_dir = dir_t'(preempt_dir);
`else
    assign pre_act = 1'b0;
    assign pre_dir = DIR_N;
`endif

    phase_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    dir_t             last_q, last_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0][1:0]  lights_q, lights_d;

    logic [3:0]       rr_gnt, green_gnt, others;
    logic             rr_valid, enter_green, min_done, max_done, own_preempt;
    logic [CNT_W:0]   elapsed;

    rr_arbiter4 u_arb (
        .req   (pending_q),
        .last  (last_q),
        .gnt   (rr_gnt),
        .valid (rr_valid)
    );

    // elapsed counts the tick landing on this edge, so an N-tick phase exits at count N-1 with tick_en.
    assign timer_inc   = (tick_en && timer_q != TIMER_MAX) ? timer_q + 1'b1 : timer_q;
    assign elapsed     = {1'b0, timer_q} + (CNT_W+1)'(tick_en);
    assign others      = pending_q & ~grant_q;
    assign min_done    = elapsed >= MIN_TICKS;
    assign max_done    = elapsed >= MAX_TICKS;
    assign own_preempt = pre_act && (grant_q == dir_onehot(pre_dir));
    assign green_gnt   = pre_act ? dir_onehot(pre_dir) : rr_gnt;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_inc;
        last_d      = last_q;
        grant_d     = grant_q;
        enter_green = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pre_act || rr_valid) enter_green = 1'b1;
            end
            GREEN_PH: begin
                if (!own_preempt &&
                    (pre_act || (others != 4'b0000 && (min_done || max_done)))) begin
                    state_d = YELLOW_PH;
                    timer_d = '0;
                end
            end
            YELLOW_PH: begin
                if (tick_en && timer_q == YEL_LAST) begin
                    state_d = ALLRED_PH;
                    timer_d = '0;
                    grant_d = 4'b0000;
                end
            end
            ALLRED_PH: begin
                if (tick_en && timer_q == AR_LAST) begin
                    if (pre_act || rr_valid) begin
                        enter_green = 1'b1;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                grant_d = 4'b0000;
            end
        endcase
        if (enter_green) begin
            state_d = GREEN_PH;
            timer_d = '0;
            grant_d = green_gnt;
            last_d  = onehot_to_dir(green_gnt);
        end
        // A grant on this edge beats a simultaneous new request for the same approach.
        pending_d = (pending_q | (req & ~grant_q)) & ~(enter_green ? green_gnt : 4'b0000);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lights
        assign lights_d[gi] = !grant_d[gi]            ? RED   :
                              (state_d == GREEN_PH)   ? GREEN : YELLOW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            last_q    <= DIR_W;
            grant_q   <= 4'b0000;
            pending_q <= 4'b0000;
            lights_q  <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            lights_q  <= lights_d;
        end
    end

    assign n_lights = lights_q[0];
    assign s_lights = lights_q[1];
    assign e_lights = lights_q[2];
    assign w_lights = lights_q[3];
    assign grant    = grant_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: vector table, hand-written corner sequences, and a random run
// against an event-level reference model (two instances: default and GREEN_MIN=12).
module tb_traffic_phase_scheduler;

    localparam int GMAX = 12;
    localparam int YEL  = 3;
    localparam int AR   = 1;
`ifdef EMERGENCY_PREEMPT_EN
    localparam bit HAS_PRE = 1'b1;
`else
    localparam bit HAS_PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       pre = 1'b0;
    logic [1:0] pdir = 2'd0;

    logic [1:0] n0, s0, e0, w0, n1, s1, e1, w1;
    logic [3:0] g0, p0, g1, p1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut0 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .req(req),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt(pre), .preempt_dir(pdir),
`endif
        .n_lights(n0), .s_lights(s0), .e_lights(e0), .w_lights(w0),
        .grant(g0), .pending(p0)
    );

    traffic_phase_scheduler #(.GREEN_MIN(12)) dut1 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .req(req),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt(pre), .preempt_dir(pdir),
`endif
        .n_lights(n1), .s_lights(s1), .e_lights(e1), .w_lights(w1),
        .grant(g1), .pending(p1)
    );

    // Reference model: mode 0 idle, 1 green, 2 yellow, 3 all-red; el = ticks seen in the phase.
    int         m_mode[2];
    int         m_dir[2];
    int         m_el[2];
    int         m_last[2];
    logic [3:0] m_pend[2];
    int         gmin[2] = '{4, 12};

    function automatic int rr_pick(input int last, input logic [3:0] p);
        for (int k = 1; k <= 4; k++) begin
            if (p[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_grant(input int k);
        logic [3:0] g;
        g = 4'b0000;
        if (m_mode[k] == 1 || m_mode[k] == 2) g[m_dir[k]] = 1'b1;
        return g;
    endfunction

    function automatic logic [7:0] m_lights(input int k);
        logic [7:0] l;
        l = 8'h00;
        if (m_mode[k] == 1) l[2*m_dir[k] +: 2] = 2'b10;
        else if (m_mode[k] == 2) l[2*m_dir[k] +: 2] = 2'b01;
        return l;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_dir[k] = 0; m_el[k] = 0; m_last[k] = 3; m_pend[k] = 4'b0000;
        end
    endtask

    task automatic m_step(input int k);
        logic [3:0] held, newp, oth;
        int el_n, granted;
        bit pa;
        pa      = HAS_PRE && pre;
        held    = m_grant(k);
        el_n    = m_el[k] + int'(tick_en);
        granted = -1;
        case (m_mode[k])
            0: begin
                if (pa) granted = int'(pdir);
                else if (m_pend[k] != 0) granted = rr_pick(m_last[k], m_pend[k]);
            end
            1: begin
                oth = m_pend[k] & ~held;
                if (pa && int'(pdir) == m_dir[k]) m_el[k] = el_n;
                else if (pa || (oth != 0 && (el_n >= gmin[k] || el_n >= GMAX))) begin
                    m_mode[k] = 2; m_el[k] = 0;
                end else m_el[k] = el_n;
            end
            2: begin
                if (el_n >= YEL) begin m_mode[k] = 3; m_el[k] = 0; end
                else m_el[k] = el_n;
            end
            default: begin
                if (el_n >= AR) begin
                    if (pa) granted = int'(pdir);
                    else if (m_pend[k] != 0) granted = rr_pick(m_last[k], m_pend[k]);
                    else begin m_mode[k] = 0; m_el[k] = 0; end
                end else m_el[k] = el_n;
            end
        endcase
        newp = m_pend[k] | (req & ~held);
        if (granted >= 0) begin
            m_mode[k] = 1; m_dir[k] = granted; m_last[k] = granted; m_el[k] = 0;
            newp[granted] = 1'b0;
        end
        m_pend[k] = newp;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input int k);
        if (k == 0) begin
            check("rnd0_grant", 32'(g0), 32'(m_grant(0)));
            check("rnd0_pending", 32'(p0), 32'(m_pend[0]));
            check("rnd0_lights", 32'({w0, e0, s0, n0}), 32'(m_lights(0)));
        end else begin
            check("rnd1_grant", 32'(g1), 32'(m_grant(1)));
            check("rnd1_pending", 32'(p1), 32'(m_pend[1]));
            check("rnd1_lights", 32'({w1, e1, s1, n1}), 32'(m_lights(1)));
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic t);
        @(negedge clk);
        req = r;
        tick_en = t;
        @(posedge clk);
        m_step(0);
        m_step(1);
        #1;
    endtask

    // Asserts reset between edges, so the all-red check also covers the asynchronous path.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0; req = 4'b0000; tick_en = 1'b0; pre = 1'b0;
        #1;
        check("rst_grant", 32'(g0), 32'h0);
        check("rst_pending", 32'(p0), 32'h0);
        check("rst_lights", 32'({w0, e0, s0, n0, w1, e1, s1, n1}), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        $display("reset applied");
    endtask

    typedef struct {
        logic [3:0] req;
        logic       tick;
        logic [3:0] grant;
        logic [3:0] pend;
        logic [7:0] lights;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] order[5];
        logic [3:0] gm, cur, r;
        int found, len;

        vecs[0]  = '{4'b0001, 1'b0, 4'b0000, 4'b0001, 8'h00};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0001, 4'b0000, 8'h02};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0001, 4'b0000, 8'h02};
        vecs[3]  = '{4'b0100, 1'b1, 4'b0001, 4'b0100, 8'h02};
        vecs[4]  = '{4'b0000, 1'b0, 4'b0001, 4'b0100, 8'h02};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0001, 4'b0100, 8'h02};
        vecs[6]  = '{4'b0000, 1'b1, 4'b0001, 4'b0100, 8'h01};
        vecs[7]  = '{4'b0000, 1'b1, 4'b0001, 4'b0100, 8'h01};
        vecs[8]  = '{4'b0000, 1'b1, 4'b0001, 4'b0100, 8'h01};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 8'h00};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 8'h00};
        vecs[11] = '{4'b0000, 1'b1, 4'b0100, 4'b0000, 8'h20};
        vecs[12] = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 8'h20};
        vecs[13] = '{4'b0001, 1'b0, 4'b0100, 4'b0001, 8'h20};

        // Table: N served from idle, E pulsed mid-green, full N->yellow->all-red->E sequence.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].req, vecs[i].tick);
            $display("vec %0d req=%b tick=%b grant=%b pending=%b lights=%h",
                     i, vecs[i].req, vecs[i].tick, g0, p0, {w0, e0, s0, n0});
            check($sformatf("vec%0d_grant", i), 32'(g0), 32'(vecs[i].grant));
            check($sformatf("vec%0d_pending", i), 32'(p0), 32'(vecs[i].pend));
            check($sformatf("vec%0d_lights", i), 32'({w0, e0, s0, n0}), 32'(vecs[i].lights));
        end

        // Own-approach request during green is not latched; N is not re-served after S.
        do_reset();
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        check("own_n_green", 32'(g0), 32'h1);
        cycle(4'b0011, 1'b0);
        check("own_pending", 32'(p0), 32'h2);
        repeat (4) cycle(4'b0000, 1'b1);
        check("own_n_yellow", 32'({w0, e0, s0, n0}), 32'h01);
        repeat (3) cycle(4'b0000, 1'b1);
        check("own_allred", 32'({w0, e0, s0, n0}), 32'h00);
        cycle(4'b0000, 1'b1);
        check("own_s_green", 32'({w0, e0, s0, n0}), 32'h08);
        repeat (10) cycle(4'b0000, 1'b1);
        check("own_s_rest", 32'(g0), 32'h2);
        check("own_no_reserve", 32'(p0), 32'h0);
        $display("seq own-request done grant=%b", g0);

        // GREEN_MIN=12 instance: S forced to yellow at its 12th tick, W next.
        do_reset();
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        check("max_s_green", 32'(g1), 32'h2);
        cycle(4'b1000, 1'b0);
        repeat (11) cycle(4'b0000, 1'b1);
        check("max_s_hold11", 32'({w1, e1, s1, n1}), 32'h08);
        cycle(4'b0000, 1'b1);
        check("max_s_yellow12", 32'({w1, e1, s1, n1}), 32'h04);
        repeat (4) cycle(4'b0000, 1'b1);
        check("max_w_green", 32'({w1, e1, s1, n1}), 32'h80);
        check("max_w_grant", 32'(g1), 32'h8);
        $display("seq green-max done grant=%b", g1);

        // All requests held: strict N,S,E,W,N rotation, each green exactly GREEN_MIN ticks.
        do_reset();
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        found = 0; len = 0; cur = 4'b0000;
        for (int c = 0; c < 200 && found < 6; c++) begin
            cycle(4'b1111, 1'b1);
            gm = {w0 == 2'b10, e0 == 2'b10, s0 == 2'b10, n0 == 2'b10};
            if (gm != 4'b0000 && gm != cur) begin
                if (cur != 4'b0000) check($sformatf("rr_len%0d", found - 1), 32'(len), 32'd4);
                if (found < 5) check($sformatf("rr_order%0d", found), 32'(gm), 32'(order[found]));
                found++;
                cur = gm;
                len = 1;
            end else if (gm != 4'b0000) begin
                len++;
            end
        end
        check("rr_greens_seen", 32'(found), 32'd6);
        $display("seq round-robin done greens=%0d", found);

`ifdef EMERGENCY_PREEMPT_EN
        // Pre-emption toward W while E is green: E cut short, W held past GREEN_MAX.
        do_reset();
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        check("pre_e_green", 32'(g0), 32'h4);
        cycle(4'b0000, 1'b1);
        pre = 1'b1; pdir = 2'd3;
        cycle(4'b0001, 1'b0);
        check("pre_e_yellow", 32'({w0, e0, s0, n0}), 32'h10);
        repeat (3) cycle(4'b0000, 1'b1);
        check("pre_allred", 32'(g0), 32'h0);
        cycle(4'b0000, 1'b1);
        check("pre_w_green", 32'({w0, e0, s0, n0}), 32'h80);
        repeat (20) cycle(4'b0000, 1'b1);
        check("pre_w_hold", 32'({w0, e0, s0, n0}), 32'h80);
        check("pre_n_pending", 32'(p0), 32'h1);
        pre = 1'b0;
        cycle(4'b0000, 1'b1);
        check("pre_release", 32'({w0, e0, s0, n0}), 32'h40);
        $display("seq preempt done grant=%b", g0);
`endif

        // Randomized run against the reference model, both instances.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = 1'b1;
            end
            if (HAS_PRE && $urandom_range(0, 59) == 0) begin
                pre  = ~pre;
                pdir = 2'($urandom_range(0, 3));
            end
            cycle(r, 1'($urandom_range(0, 1)));
            check_model(0);
            check_model(1);
        end
        pre = 1'b0;
        $display("random run done cycles=3000");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
